// File: rtl/morse_sequencer_if.sv
// Letter request / LED status bundle between the letter decoder, the Morse
// sequencer and the LED outputs.
interface morse_sequencer_if;
  logic       start_i;
  logic [3:0] code_i;
  logic [2:0] size_i;
  logic       repeat_i;
  logic       dot_o;
  logic       dash_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] state_o;

  modport master (
    output start_i, code_i, size_i, repeat_i,
    input  dot_o, dash_o, busy_o, done_o, state_o
  );

  modport slave (
    input  start_i, code_i, size_i, repeat_i,
    output dot_o, dash_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/morse_sequencer.sv
// Plays one latched Morse letter MSB-first on dot/dash LEDs with unit-based timing.
// Optional looping playback is enabled by defining MORSE_REPEAT_EN.
module morse_sequencer #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int MAX_LEN    = 4,
  parameter int DOT_UNITS  = 1,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 1,
  parameter int LGAP_UNITS = 3
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  morse_sequencer_if.slave  ms
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MARK = 2'b01,
    S_GAP  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int PRESC_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int EXTRA_UNITS = LGAP_UNITS - GAP_UNITS;
  localparam int MAX_A       = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
  localparam int MAX_B       = (GAP_UNITS > EXTRA_UNITS) ? GAP_UNITS : EXTRA_UNITS;
  localparam int MAX_UNITS   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int UNIT_W      = ($clog2(MAX_UNITS) > 2) ? $clog2(MAX_UNITS) : 2;
  // The code word is 4 bits wide, so lengths beyond that cannot be addressed.
  localparam int LEN_CAP     = (MAX_LEN > 4) ? 4 : MAX_LEN;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [UNIT_W-1:0]  DOT_LAST   = UNIT_W'(DOT_UNITS - 1);
  localparam logic [UNIT_W-1:0]  DASH_LAST  = UNIT_W'(DASH_UNITS - 1);
  localparam logic [UNIT_W-1:0]  GAP_LAST   = UNIT_W'(GAP_UNITS - 1);
  localparam logic [2:0]         LEN_CAP_C  = 3'(LEN_CAP);

  state_t               state_reg, state_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [UNIT_W-1:0]    unit_reg, unit_next;
  logic [2:0]           rem_reg, rem_next;
  logic [3:0]           code_reg, code_next;
  logic                 dot_reg, dot_next;
  logic                 dash_reg, dash_next;
  logic                 done_reg, done_next;
  logic                 busy_reg, busy_next;

`ifdef MORSE_REPEAT_EN
  localparam logic [UNIT_W-1:0] EXTRA_LAST = (EXTRA_UNITS > 0) ? UNIT_W'(EXTRA_UNITS - 1) : '0;
  logic [2:0] size_reg, size_next;
  logic       lgap_reg, lgap_next;
  logic       replay_reg, replay_next;
`endif

  logic [2:0]        size_clamped;
  logic [1:0]        cur_idx;
  logic              cur_bit;
  logic [UNIT_W-1:0] unit_last;
  logic              tick_last;
  logic              phase_end;
  logic [1:0]        next_idx;
  logic              next_bit;

  assign size_clamped = (ms.size_i > LEN_CAP_C) ? LEN_CAP_C : ms.size_i;

  // rem_reg counts symbols still to play including the current one, so the
  // active bit sits at rem-1; only the low two bits are needed to address it.
  assign cur_idx = rem_reg[1:0] - 2'd1;
  assign cur_bit = code_reg[cur_idx];

  always_comb begin
    unit_last = GAP_LAST;
    if (state_reg == S_MARK) begin
      unit_last = cur_bit ? DASH_LAST : DOT_LAST;
    end
`ifdef MORSE_REPEAT_EN
    else if (lgap_reg) begin
      unit_last = EXTRA_LAST;
    end
`endif
  end

  assign tick_last = (presc_reg == PRESC_LAST);
  assign phase_end = tick_last && (unit_reg == unit_last);

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    unit_next  = unit_reg;
    rem_next   = rem_reg;
    code_next  = code_reg;
`ifdef MORSE_REPEAT_EN
    size_next   = size_reg;
    lgap_next   = lgap_reg;
    replay_next = replay_reg;
`endif

    if ((state_reg == S_MARK) || (state_reg == S_GAP)) begin
      if (tick_last) begin
        presc_next = '0;
        unit_next  = (unit_reg == unit_last) ? '0 : unit_reg + 1'b1;
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (ms.start_i) begin
          code_next  = ms.code_i;
          rem_next   = size_clamped;
          presc_next = '0;
          unit_next  = '0;
`ifdef MORSE_REPEAT_EN
          size_next  = size_clamped;
`endif
          state_next = (size_clamped == 3'd0) ? S_DONE : S_MARK;
        end
      end
      S_MARK: begin
        if (phase_end) begin
          state_next = S_GAP;
          rem_next   = rem_reg - 3'd1;
        end
      end
      S_GAP: begin
        if (phase_end) begin
          if (rem_reg != 3'd0) begin
            state_next = S_MARK;
          end else begin
`ifdef MORSE_REPEAT_EN
            // repeat_i is only looked at here; the extended gap then runs to completion.
            if (lgap_reg) begin
              lgap_next   = 1'b0;
              replay_next = 1'b1;
              state_next  = S_DONE;
            end else if (ms.repeat_i) begin
              if (EXTRA_UNITS > 0) begin
                lgap_next = 1'b1;
              end else begin
                replay_next = 1'b1;
                state_next  = S_DONE;
              end
            end else begin
              state_next = S_DONE;
            end
`else
            state_next = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
`ifdef MORSE_REPEAT_EN
        if (replay_reg) begin
          replay_next = 1'b0;
          rem_next    = size_reg;
          presc_next  = '0;
          unit_next   = '0;
          state_next  = S_MARK;
        end else begin
          state_next = S_IDLE;
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the LEDs change on the same
  // edge as the state register.
  assign next_idx = rem_next[1:0] - 2'd1;
  assign next_bit = code_next[next_idx];

  always_comb begin
    dot_next  = (state_next == S_MARK) && !next_bit;
    dash_next = (state_next == S_MARK) &&  next_bit;
    done_next = (state_next == S_DONE);
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      presc_reg <= '0;
      unit_reg  <= '0;
      rem_reg   <= '0;
      code_reg  <= '0;
      dot_reg   <= 1'b0;
      dash_reg  <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      unit_reg  <= unit_next;
      rem_reg   <= rem_next;
      code_reg  <= code_next;
      dot_reg   <= dot_next;
      dash_reg  <= dash_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

`ifdef MORSE_REPEAT_EN
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      size_reg   <= '0;
      lgap_reg   <= 1'b0;
      replay_reg <= 1'b0;
    end else begin
      size_reg   <= size_next;
      lgap_reg   <= lgap_next;
      replay_reg <= replay_next;
    end
  end
`endif

  assign ms.dot_o   = dot_reg;
  assign ms.dash_o  = dash_reg;
  assign ms.done_o  = done_reg;
  assign ms.busy_o  = busy_reg;
  assign ms.state_o = state_reg;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer (TICK_DIV=4): stimulus queues expected
// mark timings per letter, a monitor compares them at each done_o pulse.
module tb_morse_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  morse_sequencer_if ms_if ();

  morse_sequencer #(.TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .ms       (ms_if)
  );

  typedef struct packed {
    int              base;
    int              done_off;
    int              n;
    logic [3:0]      kinds;
    logic [3:0][15:0] st;
    logic [3:0][15:0] en;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_letter(input int base, input int done_off, input int n,
                               input logic [3:0] kinds, input logic [63:0] st,
                               input logic [63:0] en);
    exp_t e;
    e.base = base; e.done_off = done_off; e.n = n;
    e.kinds = kinds; e.st = st; e.en = en;
    exp_q.push_back(e);
    $display("queued letter base=%0d n=%0d done_at=%0d", base, n, base + done_off);
  endtask

  // Monitor: rebuilds the mark list from the LED waveform and checks it on done_o.
  int   obs_kind[8];
  int   obs_s[8];
  int   obs_e[8];
  int   obs_n;
  int   dot_s, dash_s;
  logic prev_dot, prev_dash, overlap, idle_chk;

  task automatic record(input int kind, input int s, input int e);
    if (obs_n < 8) begin
      obs_kind[obs_n] = kind; obs_s[obs_n] = s; obs_e[obs_n] = e;
      obs_n++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      obs_n = 0; prev_dot = 0; prev_dash = 0; overlap = 0; idle_chk = 0;
    end else begin
      if (idle_chk) begin
        check("idle_state", 32'(ms_if.state_o), 32'd0);
        check("idle_busy", 32'(ms_if.busy_o), 32'd0);
        idle_chk = 0;
      end
      if (ms_if.dot_o && ms_if.dash_o) overlap = 1;
      if (ms_if.dot_o && !prev_dot) dot_s = cyc;
      if (!ms_if.dot_o && prev_dot) record(0, dot_s, cyc - 1);
      if (ms_if.dash_o && !prev_dash) dash_s = cyc;
      if (!ms_if.dash_o && prev_dash) record(1, dash_s, cyc - 1);
      prev_dot  = ms_if.dot_o;
      prev_dash = ms_if.dash_o;
      if (ms_if.done_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cyc %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cyc", 32'(cyc), 32'(e.base + e.done_off));
          check("n_marks", 32'(obs_n), 32'(e.n));
          for (int i = 0; i < 4; i++) begin
            if (i < e.n && i < obs_n) begin
              check("mark_kind", 32'(obs_kind[i]), 32'(e.kinds[i]));
              check("mark_start", 32'(obs_s[i]), 32'(e.base + int'(e.st[i])));
              check("mark_end", 32'(obs_e[i]), 32'(e.base + int'(e.en[i])));
            end
          end
          check("done_state", 32'(ms_if.state_o), 32'd3);
          check("done_busy", 32'(ms_if.busy_o), 32'd1);
          check("led_overlap", 32'(overlap), 32'd0);
          $display("done_o at cyc %0d marks=%0d", cyc, obs_n);
        end
        obs_n = 0; overlap = 0; idle_chk = 1;
      end
    end
  end

  task automatic start_letter(input logic [3:0] code, input logic [2:0] size, output int base);
    @(posedge clk); #1;
    ms_if.code_i  = code;
    ms_if.size_i  = size;
    ms_if.start_i = 1'b1;
    base = cyc;
    @(posedge clk); #1;
    ms_if.start_i = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int b;
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1;
    ms_if.start_i = 1'b0; ms_if.code_i = 4'd0; ms_if.size_i = 3'd0; ms_if.repeat_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dot", 32'(ms_if.dot_o), 32'd0);
    check("rst_dash", 32'(ms_if.dash_o), 32'd0);
    check("rst_done", 32'(ms_if.done_o), 32'd0);
    check("rst_busy", 32'(ms_if.busy_o), 32'd0);
    check("rst_state", 32'(ms_if.state_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 'A': dot then dash
    start_letter(4'b0001, 3'd2, b);
    expect_letter(b, 25, 2, 4'b0010, {16'd0, 16'd0, 16'd9, 16'd1}, {16'd0, 16'd0, 16'd20, 16'd4});
    wait_drain(100);

    // size 0: immediate DONE, no LEDs
    start_letter(4'b1111, 3'd0, b);
    expect_letter(b, 1, 0, 4'b0000, 64'd0, 64'd0);
    wait_drain(20);

    // size 5 clamped to 4 dashes
    start_letter(4'b1111, 3'd5, b);
    expect_letter(b, 65, 4, 4'b1111, {16'd49, 16'd33, 16'd17, 16'd1}, {16'd60, 16'd44, 16'd28, 16'd12});
    wait_drain(120);

    // dash dot dash dot
    start_letter(4'b1010, 3'd4, b);
    expect_letter(b, 49, 4, 4'b0101, {16'd41, 16'd25, 16'd17, 16'd1}, {16'd44, 16'd36, 16'd20, 16'd12});
    wait_drain(100);

    // 'O'-prefix style: bits 2..0 of 0110 -> dash dash dot
    start_letter(4'b0110, 3'd3, b);
    expect_letter(b, 41, 3, 4'b0011, {16'd0, 16'd33, 16'd17, 16'd1}, {16'd0, 16'd36, 16'd28, 16'd12});
    wait_drain(100);

    // 'E': single dot
    start_letter(4'b0000, 3'd1, b);
    expect_letter(b, 9, 1, 4'b0000, {16'd0, 16'd0, 16'd0, 16'd1}, {16'd0, 16'd0, 16'd0, 16'd4});
    wait_drain(40);

    // Reset mid-dash, then replay from the first symbol
    start_letter(4'b0001, 3'd2, b);
    wait_cyc(b + 12);
    check("pre_rst_dash", 32'(ms_if.dash_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_dot", 32'(ms_if.dot_o), 32'd0);
    check("midrst_dash", 32'(ms_if.dash_o), 32'd0);
    check("midrst_state", 32'(ms_if.state_o), 32'd0);
    check("midrst_busy", 32'(ms_if.busy_o), 32'd0);
    $display("reset asserted mid-dash at cyc %0d", cyc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    start_letter(4'b0001, 3'd2, b);
    expect_letter(b, 25, 2, 4'b0010, {16'd0, 16'd0, 16'd9, 16'd1}, {16'd0, 16'd0, 16'd20, 16'd4});
    wait_drain(100);

    // Inputs disturbed mid-letter: waveform must match plain 'A'
    start_letter(4'b0001, 3'd2, b);
    expect_letter(b, 25, 2, 4'b0010, {16'd0, 16'd0, 16'd9, 16'd1}, {16'd0, 16'd0, 16'd20, 16'd4});
    wait_cyc(b + 3);
    ms_if.start_i = 1'b1; ms_if.code_i = 4'b1111; ms_if.size_i = 3'd4;
    wait_cyc(b + 7);
    ms_if.start_i = 1'b0;
    wait_cyc(b + 10);
    ms_if.start_i = 1'b1; ms_if.code_i = 4'b0000; ms_if.size_i = 3'd0;
    wait_cyc(b + 22);
    ms_if.start_i = 1'b0; ms_if.code_i = 4'b1010;
    wait_drain(100);

    // size 0 with start held: second DONE two cycles after the first
    @(posedge clk); #1;
    ms_if.code_i = 4'b0000; ms_if.size_i = 3'd0; ms_if.start_i = 1'b1;
    b = cyc;
    expect_letter(b, 1, 0, 4'b0000, 64'd0, 64'd0);
    expect_letter(b + 2, 1, 0, 4'b0000, 64'd0, 64'd0);
    wait_cyc(b + 3);
    ms_if.start_i = 1'b0;
    wait_drain(20);

    // 'A' with start held through DONE restarts in the first IDLE cycle
    @(posedge clk); #1;
    ms_if.code_i = 4'b0001; ms_if.size_i = 3'd2; ms_if.start_i = 1'b1;
    b = cyc;
    expect_letter(b, 25, 2, 4'b0010, {16'd0, 16'd0, 16'd9, 16'd1}, {16'd0, 16'd0, 16'd20, 16'd4});
    expect_letter(b + 26, 25, 2, 4'b0010, {16'd0, 16'd0, 16'd9, 16'd1}, {16'd0, 16'd0, 16'd20, 16'd4});
    wait_cyc(b + 27);
    ms_if.start_i = 1'b0;
    wait_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d cycles required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
